univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: en  input  1  register update enable; 0 = hold regardless of mode.
REQ-005 Port: mode  input  3  operation select, encoded per REQ-011.
REQ-006 Port: sin_r  input  1  serial input entering at bit 0 during shift-left.
REQ-007 Port: sin_l  input  1  serial input entering at bit WIDTH-1 during shift-right.
REQ-008 Port: D  input  WIDTH  parallel load data.
REQ-009 Port: Q  output  WIDTH  register contents; Qbar  output  WIDTH  bitwise complement of Q.
REQ-010 Port: sout_l  output  1  equals Q[WIDTH-1]; sout_r  output  1  equals Q[0]; zero  output  1  high when Q is all zeros; par  output  1  XOR of all Q bits.

Function
REQ-011 The mode encoding shall be: 000 hold, 001 shift-left, 010 shift-right, 011 parallel load, 100 rotate-left, 101 rotate-right, 110 clear, 111 invert.
REQ-012 Q shall change only on a rising clk edge with en=1, or on rst; all updates take effect one cycle after sampling (latency 1).
REQ-013 Shift-left: Q <= {Q[WIDTH-2:0], sin_r}; shift-right: Q <= {sin_l, Q[WIDTH-1:1]}.
REQ-014 Rotate-left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; rotate-right: Q <= {Q[0], Q[WIDTH-1:1]}; sin_l and sin_r are ignored.
REQ-015 Parallel load: Q <= D; clear: Q <= 0; invert: Q <= ~Q (each bit behaves as a T flip-flop with T=1).
REQ-016 Hold (mode 000 or en=0) shall leave Q unchanged indefinitely.
REQ-017 Qbar shall equal ~Q in every cycle, including during and immediately after reset; no cycle in which Q[i]==Qbar[i].
REQ-018 sout_l, sout_r, zero and par shall be purely combinational from Q (no added register latency).
REQ-019 Wrap-around: after WIDTH consecutive rotates in one direction, Q shall equal its starting value; after WIDTH consecutive shifts Q shall consist entirely of the shifted-in serial bits.
REQ-020 Mode and data inputs shall be sampled only at the rising edge; changes between edges shall have no effect on Q.
REQ-021 Any mode value, including invalid X, shall never cause Q to take a value other than those in REQ-013..REQ-016; implementation uses a full case with hold as default.

Reset
REQ-022 When rst=1, Q shall go to 0 immediately without waiting for clk; Qbar = all ones, sout_l=0, sout_r=0, zero=1, par=0.
REQ-023 While rst=1, clock edges, en and mode shall be ignored.
REQ-024 On rst deassertion, the first update shall occur at the first rising clk edge where rst=0 and en=1; rst asserted mid-operation (e.g. partway through a rotate sequence) discards the state.

Verification
REQ-025 WIDTH=8, rst pulse asynchronous between edges -> Q=8'h00, Qbar=8'hFF, zero=1 before the next clk edge.
REQ-026 Load D=8'hA5 (mode 011, en=1) -> next cycle Q=8'hA5, Qbar=8'h5A, par=0, zero=0; then mode 111 -> Q=8'h5A.
REQ-027 Q=8'h81, rotate-left once -> Q=8'h03; rotate-right 8 times from 8'h03 -> Q=8'h03 each 8th cycle.
REQ-028 Q=8'hA5, shift-right with sin_l=1 -> Q=8'hD2, sout_r=0; then shift-left with sin_r=0 -> Q=8'hA4.
REQ-029 Q=8'hA5, en=0 with mode cycling through all 8 codes for 8 cycles -> Q stays 8'hA5; then mode 110, en=1 -> Q=8'h00, zero=1.
REQ-030 Bench runs with a 10 ns clock, prints time, mode, Q, Qbar on every change, dumps waveforms, and checks Qbar==~Q every cycle.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Universal WIDTH-bit shift register: hold, shift left/right with serial
//   inputs, parallel load, rotate left/right, clear and invert. There is
//   one register update per enabled rising clock edge. Reset is
//   asynchronous and active-high, and it forces the register to zero.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   en      in   update enable (0 = hold whatever the mode)
//   mode    in   [2:0] operation select
//                000 hold, 001 shl, 010 shr, 011 load,
//                100 rotl, 101 rotr, 110 clear, 111 invert
//   sin_r   in   serial bit entering at bit 0 on shift-left
//   sin_l   in   serial bit entering at bit WIDTH-1 on shift-right
//   D       in   [WIDTH-1:0] parallel load data
//   Q       out  [WIDTH-1:0] register contents
//   Qbar    out  [WIDTH-1:0] ~Q
//   sout_l  out  Q[WIDTH-1]
//   sout_r  out  Q[0]
//   zero    out  Q == 0
//   par     out  XOR reduction of Q
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero,
    output logic             par
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_INV   = 3'b111;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection. The default branch holds, so an unknown or
    // undecodable mode can only ever keep the current contents.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                M_HOLD:  q_d = q_q;
                M_SHL:   q_d = {q_q[WIDTH-2:0], sin_r};
                M_SHR:   q_d = {sin_l, q_q[WIDTH-1:1]};
                M_LOAD:  q_d = D;
                M_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                M_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                M_CLEAR: q_d = '0;
                M_INV:   q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // The status outputs are derived directly from the register with no
    // further register stage. This keeps Qbar the exact complement of Q
    // in every cycle, reset included.
    assign Q      = q_q;
    assign Qbar   = ~q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign zero   = ~|q_q;
    assign par    = ^q_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qbar;
    logic         sout_l;
    logic         sout_r;
    logic         zero;
    logic         par;

    int n_chk;
    int n_pass;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .D      (D),
        .Q      (Q),
        .Qbar   (Qbar),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .zero   (zero),
        .par    (par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial $monitor("t=%0t mode=%b Q=%h Qbar=%h", $time, mode, Q, Qbar);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock edge, then sample 1 ns later and check the complement invariant.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("qbar_inv", {24'd0, Qbar}, {24'd0, ~Q});
    endtask

    task automatic op(input logic [2:0] m, input logic [W-1:0] d);
        en   = 1'b1;
        mode = m;
        D    = d;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        en     = 1'b0;
        mode   = 3'b000;
        sin_r  = 1'b0;
        sin_l  = 1'b0;
        D      = '0;

        // Reset state, held across edges with en/mode active
        #2;
        en = 1'b1; mode = 3'b011; D = 8'hFF;
        tick();
        tick();
        chk("rst_q",      {24'd0, Q},    32'h00);
        chk("rst_qbar",   {24'd0, Qbar}, 32'hFF);
        chk("rst_zero",   {31'd0, zero},   32'd1);
        chk("rst_par",    {31'd0, par},    32'd0);
        chk("rst_sout_l", {31'd0, sout_l}, 32'd0);
        chk("rst_sout_r", {31'd0, sout_r}, 32'd0);
        rst = 1'b0;

        // Load then async reset between edges
        op(3'b011, 8'h5C);
        chk("pre_arst_q", {24'd0, Q}, 32'h5C);
        #2 rst = 1'b1;
        #1;
        chk("arst_q",    {24'd0, Q},    32'h00);
        chk("arst_qbar", {24'd0, Qbar}, 32'hFF);
        chk("arst_zero", {31'd0, zero}, 32'd1);
        #1 rst = 1'b0;

        // Load A5, then invert
        op(3'b011, 8'hA5);
        chk("load_q",    {24'd0, Q},    32'hA5);
        chk("load_qbar", {24'd0, Qbar}, 32'h5A);
        chk("load_par",  {31'd0, par},  32'd0);
        chk("load_zero", {31'd0, zero}, 32'd0);
        op(3'b111, 8'h00);
        chk("inv_q", {24'd0, Q}, 32'h5A);

        // Rotates
        op(3'b011, 8'h81);
        op(3'b100, 8'h00);
        chk("rotl_q", {24'd0, Q}, 32'h03);
        op(3'b101, 8'h00);
        chk("rotr1_q", {24'd0, Q}, 32'h81);
        for (int i = 1; i < 8; i++) op(3'b101, 8'h00);
        chk("rotr8_q", {24'd0, Q}, 32'h03);
        for (int i = 0; i < 8; i++) op(3'b100, 8'h00);
        chk("rotl8_q", {24'd0, Q}, 32'h03);

        // Shifts with serial inputs; rotates ignore serial pins (checked above with 0s, here 1s)
        op(3'b011, 8'hA5);
        sin_l = 1'b1;
        op(3'b010, 8'h00);
        chk("shr_q",      {24'd0, Q},      32'hD2);
        chk("shr_sout_r", {31'd0, sout_r}, 32'd0);
        sin_r = 1'b0;
        op(3'b001, 8'h00);
        chk("shl_q",      {24'd0, Q},      32'hA4);
        chk("shl_sout_l", {31'd0, sout_l}, 32'd1);
        sin_r = 1'b1;
        op(3'b100, 8'h00);
        chk("rotl_sin_ign", {24'd0, Q}, 32'h49);

        // en=0 holds through all modes, then clear
        op(3'b011, 8'hA5);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mode = 3'(i);
            D    = 8'h3C;
            tick();
        end
        chk("en0_hold_q", {24'd0, Q}, 32'hA5);
        op(3'b110, 8'h00);
        chk("clr_q",    {24'd0, Q},    32'h00);
        chk("clr_zero", {31'd0, zero}, 32'd1);

        // Mode 000 holds; mid-cycle input changes not sampled
        op(3'b000, 8'h77);
        chk("hold_q", {24'd0, Q}, 32'h00);
        mode = 3'b011; D = 8'hEE;
        #3 mode = 3'b000;
        tick();
        chk("between_edge_q", {24'd0, Q}, 32'h00);

        // 8 shift-lefts of 1s fill the register
        sin_r = 1'b1;
        for (int i = 0; i < 8; i++) op(3'b001, 8'h00);
        chk("shl8_q",   {24'd0, Q},   32'hFF);
        chk("shl8_par", {31'd0, par}, 32'd0);
        sin_l = 1'b0;
        for (int i = 0; i < 8; i++) op(3'b010, 8'h00);
        chk("shr8_q", {24'd0, Q}, 32'h00);

        // Unknown mode holds
        op(3'b011, 8'h96);
        op(3'bxxx, 8'h00);
        chk("modex_q", {24'd0, Q}, 32'h96);

        // Reset partway through a rotate sequence discards state
        op(3'b011, 8'h81);
        for (int i = 0; i < 3; i++) op(3'b100, 8'h00);
        chk("rot3_q", {24'd0, Q}, 32'h0C);
        #2 rst = 1'b1;
        #1 chk("midrot_rst_q", {24'd0, Q}, 32'h00);
        op(3'b011, 8'h55);
        chk("rst_held_q", {24'd0, Q}, 32'h00);
        rst = 1'b0;
        en  = 1'b0;
        tick();
        chk("post_rst_en0_q", {24'd0, Q}, 32'h00);
        op(3'b011, 8'h3C);
        chk("post_rst_load_q", {24'd0, Q}, 32'h3C);
        chk("par_even",        {31'd0, par}, 32'd0);
        op(3'b011, 8'h01);
        chk("par_odd",  {31'd0, par},    32'd1);
        chk("sout_r_1", {31'd0, sout_r}, 32'd1);
        chk("zero_0",   {31'd0, zero},   32'd0);

        $monitoroff;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
